// File: rtl/sgmii_pkg.sv
// Shared definitions for the SGMII link supervisor: state encodings, speed codes,
// link-partner ability bit positions and the per-state control decode.
package sgmii_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_RST_XCVR  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_AN_START  = 3'd4,
        ST_AN_WAIT   = 3'd5,
        ST_LINK_UP   = 3'd6,
        ST_BACKOFF   = 3'd7
    } state_t;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    localparam int LP_LINK     = 15;
    localparam int LP_DUPLEX   = 12;
    localparam int LP_SPEED_HI = 11;
    localparam int LP_SPEED_LO = 10;

    localparam int RST_XCVR_CYCLES = 8;

    typedef struct packed {
        logic powerDown;
        logic xcvrRst;
        logic anRestart;
        logic linkUp;
    } ctrl_t;

    function automatic ctrl_t ctrlFor(state_t s);
        ctrl_t c;
        c.powerDown = (s == ST_PWRDN);
        c.xcvrRst   = !(s inside {ST_WAIT_SYNC, ST_AN_START, ST_AN_WAIT, ST_LINK_UP});
        c.anRestart = (s == ST_AN_START);
        c.linkUp    = (s == ST_LINK_UP);
        return c;
    endfunction

    // A partner word is usable when it reports link and a defined speed code.
    function automatic logic lpQualified(logic [15:0] lp);
        return lp[LP_LINK] && (lp[LP_SPEED_HI:LP_SPEED_LO] != 2'b11);
    endfunction

endpackage

// File: rtl/sgmii_link_supervisor_if.sv
// Control/status bundle between the link supervisor and the transceiver/PCS side.
interface sgmii_link_supervisor_if;

    logic        i_Enable;
    logic        i_ANEnable;
    logic [1:0]  i2_ForceSpeed;
    logic        i_ForceDuplex;
    logic        i_PllLocked;
    logic        i_SyncStatus;
    logic        i_ANComplete;
    logic [15:0] i16_LpAdvAbility;

    logic        o_GxBPowerDown;
    logic        o_XcverDigitalRst;
    logic        o_ANRestart;
    logic        o_LinkUp;
    logic [1:0]  o2_SGMIISpeed;
    logic        o_SGMIIDuplex;
    logic        o_Fault;
    logic [2:0]  o3_State;
    logic [1:0]  o2_RetryCnt;

    modport master (
        input  i_Enable, i_ANEnable, i2_ForceSpeed, i_ForceDuplex,
        input  i_PllLocked, i_SyncStatus, i_ANComplete, i16_LpAdvAbility,
        output o_GxBPowerDown, o_XcverDigitalRst, o_ANRestart, o_LinkUp,
        output o2_SGMIISpeed, o_SGMIIDuplex, o_Fault, o3_State, o2_RetryCnt
    );

    modport slave (
        output i_Enable, i_ANEnable, i2_ForceSpeed, i_ForceDuplex,
        output i_PllLocked, i_SyncStatus, i_ANComplete, i16_LpAdvAbility,
        input  o_GxBPowerDown, o_XcverDigitalRst, o_ANRestart, o_LinkUp,
        input  o2_SGMIISpeed, o_SGMIIDuplex, o_Fault, o3_State, o2_RetryCnt
    );

endinterface

// File: rtl/sgmii_sat_timer.sv
// Saturating state-dwell timer. A clear zeroes the visible count in the same cycle,
// so the first cycle after a state change always reads as elapsed count 0.
module sgmii_sat_timer #(
    parameter int CNTR_W = 23
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Clr,
    input  logic              i_En,
    input  logic [CNTR_W-1:0] i_Terminal,
    output logic              o_Hit
);

    logic [CNTR_W-1:0] countQ;
    logic [CNTR_W-1:0] countCur;

    assign countCur = i_Clr ? '0 : countQ;
    assign o_Hit    = (countCur == i_Terminal);

    // NOTE: sequential state is written with nonblocking assignments only, so every
    // flop samples the values from before the edge regardless of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            countQ <= '0;
        end else if (i_En && (countCur != '1)) begin
            countQ <= countCur + CNTR_W'(1);
        end else begin
            countQ <= countCur;
        end
    end

endmodule

// File: rtl/sgmii_link_supervisor.sv
// SGMII bring-up sequencer: power-down, transceiver reset, lock/sync wait, AN restart,
// partner-ability qualification, and bounded retry with fault latch.
module sgmii_link_supervisor
    import sgmii_pkg::*;
#(
    parameter int PWRDN_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int SYNC_TIMEOUT   = 1048576,
    parameter int AN_TIMEOUT     = 4194304,
    parameter int BACKOFF_CYCLES = 65536,
    parameter int MAX_RETRY      = 3,
    parameter int CNTR_W         = 23
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    sgmii_link_supervisor_if.master bus
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    state_t            state;
    ctrl_t             ctrl;
    logic              timerClr;
    logic              timerHit;
    logic              fault;
    logic [1:0]        retry;
    logic [1:0]        speed;
    logic              duplex;
    logic [CNTR_W-1:0] terminal;
    logic              unusedLpBits;

    assign unusedLpBits = ^{bus.i16_LpAdvAbility[14:13], bus.i16_LpAdvAbility[9:0]};

    // NOTE: combinational blocks assign a default before the case so no path
    // leaves the output unassigned, which would otherwise infer a latch.
    always_comb begin
        terminal = '1;
        case (state)
            ST_PWRDN:     terminal = CNTR_W'(PWRDN_CYCLES - 1);
            ST_RST_XCVR:  terminal = CNTR_W'(RST_XCVR_CYCLES - 1);
            ST_WAIT_LOCK: terminal = CNTR_W'(LOCK_TIMEOUT - 1);
            ST_WAIT_SYNC: terminal = CNTR_W'(SYNC_TIMEOUT - 1);
            ST_AN_WAIT:   terminal = CNTR_W'(AN_TIMEOUT - 1);
            ST_BACKOFF:   terminal = CNTR_W'(BACKOFF_CYCLES - 1);
            default:      terminal = '1;
        endcase
    end

    sgmii_sat_timer #(
        .CNTR_W(CNTR_W)
    ) uTimer (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Clr     (timerClr),
        .i_En      (1'b1),
        .i_Terminal(terminal),
        .o_Hit     (timerHit)
    );

    task automatic goTo(input state_t nxt);
        state    <= nxt;
        ctrl     <= ctrlFor(nxt);
        timerClr <= 1'b1;
    endtask

    // Timeouts, bad partner words and PLL loss consume a retry; once exhausted the
    // supervisor parks in BACKOFF with the transceiver powered down.
    task automatic goFail();
        goTo(ST_BACKOFF);
        if (retry == RETRY_LIMIT) begin
            fault          <= 1'b1;
            ctrl.powerDown <= 1'b1;
        end else begin
            retry <= retry + 2'd1;
        end
    endtask

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= ST_PWRDN;
            ctrl     <= ctrlFor(ST_PWRDN);
            timerClr <= 1'b0;
            fault    <= 1'b0;
            retry    <= 2'd0;
            speed    <= SPD_1000;
            duplex   <= 1'b1;
        end else begin
            timerClr <= 1'b0;
            if (!bus.i_Enable) begin
                goTo(ST_PWRDN);
                fault <= 1'b0;
                retry <= 2'd0;
            end else begin
                case (state)
                    ST_PWRDN:    if (timerHit) goTo(ST_RST_XCVR);
                    ST_RST_XCVR: if (timerHit) goTo(ST_WAIT_LOCK);
                    ST_WAIT_LOCK: begin
                        if (bus.i_PllLocked) goTo(ST_WAIT_SYNC);
                        else if (timerHit)   goFail();
                    end
                    ST_WAIT_SYNC: begin
                        if (!bus.i_PllLocked) begin
                            goFail();
                        end else if (bus.i_SyncStatus) begin
                            if (bus.i_ANEnable) begin
                                goTo(ST_AN_START);
                            end else begin
                                goTo(ST_LINK_UP);
                                speed  <= bus.i2_ForceSpeed;
                                duplex <= bus.i_ForceDuplex;
                            end
                        end else if (timerHit) begin
                            goFail();
                        end
                    end
                    ST_AN_START: goTo(ST_AN_WAIT);
                    ST_AN_WAIT: begin
                        if (!bus.i_PllLocked || !bus.i_SyncStatus) begin
                            goFail();
                        end else if (bus.i_ANComplete) begin
                            if (lpQualified(bus.i16_LpAdvAbility)) begin
                                goTo(ST_LINK_UP);
                                speed  <= bus.i16_LpAdvAbility[LP_SPEED_HI:LP_SPEED_LO];
                                duplex <= bus.i16_LpAdvAbility[LP_DUPLEX];
                            end else begin
                                goFail();
                            end
                        end else if (timerHit) begin
                            goFail();
                        end
                    end
                    ST_LINK_UP: begin
                        if (!bus.i_PllLocked) begin
                            goFail();
                        end else if (!bus.i_SyncStatus || (bus.i_ANEnable && !bus.i_ANComplete)) begin
                            goTo(ST_BACKOFF);
                            retry <= 2'd0;
                        end
                    end
                    ST_BACKOFF: if (!fault && timerHit) goTo(ST_PWRDN);
                endcase
            end
        end
    end

    assign bus.o_GxBPowerDown    = ctrl.powerDown;
    assign bus.o_XcverDigitalRst = ctrl.xcvrRst;
    assign bus.o_ANRestart       = ctrl.anRestart;
    assign bus.o_LinkUp          = ctrl.linkUp;
    assign bus.o2_SGMIISpeed     = speed;
    assign bus.o_SGMIIDuplex     = duplex;
    assign bus.o_Fault           = fault;
    assign bus.o3_State          = state;
    assign bus.o2_RetryCnt       = retry;

endmodule

// File: tb/tb_sgmii_link_supervisor.sv
// Bench for the SGMII link supervisor: directed bring-up/loss/fault/reset sequences
// plus a table of partner-ability and forced-mode vectors checked through a queue.
module tb_sgmii_link_supervisor;
    import sgmii_pkg::*;

    localparam int PWRDN_CYCLES   = 16;
    localparam int LOCK_TIMEOUT   = 200;
    localparam int SYNC_TIMEOUT   = 200;
    localparam int AN_TIMEOUT     = 200;
    localparam int BACKOFF_CYCLES = 32;
    localparam int MAX_RETRY      = 3;
    localparam int CNTR_W         = 8;

    typedef struct packed {
        logic [2:0] state;
        logic       linkUp;
        logic [1:0] spd;
        logic       dup;
        logic [1:0] retry;
        logic [1:0] pulses;
    } want_t;

    typedef struct packed {
        logic [15:0] lp;
        logic        an;
        logic [1:0]  fSpd;
        logic        fDup;
        want_t       want;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sgmii_link_supervisor_if bus();

    sgmii_link_supervisor #(
        .PWRDN_CYCLES  (PWRDN_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SYNC_TIMEOUT  (SYNC_TIMEOUT),
        .AN_TIMEOUT    (AN_TIMEOUT),
        .BACKOFF_CYCLES(BACKOFF_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .CNTR_W        (CNTR_W)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    int vecCnt  = 0;
    int missCnt = 0;
    int pulseCnt = 0;

    always @(posedge clk) begin
        if (bus.o_ANRestart === 1'b1) pulseCnt <= pulseCnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vecCnt++;
        if (act !== req) begin
            missCnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitState(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (bus.o3_State !== s && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_pwrdn"},  bus.o_GxBPowerDown,    1'b1);
        check({tag, "_xrst"},   bus.o_XcverDigitalRst, 1'b1);
        check({tag, "_anrst"},  bus.o_ANRestart,       1'b0);
        check({tag, "_link"},   bus.o_LinkUp,          1'b0);
        check({tag, "_fault"},  bus.o_Fault,           1'b0);
        check({tag, "_speed"},  bus.o2_SGMIISpeed,     SPD_1000);
        check({tag, "_duplex"}, bus.o_SGMIIDuplex,     1'b1);
        check({tag, "_state"},  bus.o3_State,          3'd0);
        check({tag, "_retry"},  bus.o2_RetryCnt,       2'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[8];
        want_t sb[$];
        want_t got;
        int    n;
        int    p0;
        int    entries;
        int    lockDwell;
        logic [2:0] prevSt;

        vecs[0] = '{16'h9800, 1'b1, 2'b00, 1'b0, '{3'd6, 1'b1, SPD_1000, 1'b1, 2'd0, 2'd1}};
        vecs[1] = '{16'h8400, 1'b1, 2'b00, 1'b0, '{3'd6, 1'b1, SPD_100,  1'b0, 2'd0, 2'd1}};
        vecs[2] = '{16'h0C00, 1'b1, 2'b00, 1'b0, '{3'd7, 1'b0, SPD_100,  1'b0, 2'd1, 2'd1}};
        vecs[3] = '{16'h8000, 1'b1, 2'b00, 1'b0, '{3'd6, 1'b1, SPD_10,   1'b0, 2'd0, 2'd1}};
        vecs[4] = '{16'h8C00, 1'b1, 2'b00, 1'b0, '{3'd7, 1'b0, SPD_10,   1'b0, 2'd1, 2'd1}};
        vecs[5] = '{16'h9000, 1'b1, 2'b00, 1'b0, '{3'd6, 1'b1, SPD_10,   1'b1, 2'd0, 2'd1}};
        vecs[6] = '{16'h9800, 1'b0, 2'b01, 1'b0, '{3'd6, 1'b1, SPD_100,  1'b0, 2'd0, 2'd0}};
        vecs[7] = '{16'h0000, 1'b0, 2'b00, 1'b1, '{3'd6, 1'b1, SPD_10,   1'b1, 2'd0, 2'd0}};

        bus.i_Enable         = 1'b0;
        bus.i_ANEnable       = 1'b1;
        bus.i2_ForceSpeed    = 2'b00;
        bus.i_ForceDuplex    = 1'b0;
        bus.i_PllLocked      = 1'b0;
        bus.i_SyncStatus     = 1'b0;
        bus.i_ANComplete     = 1'b0;
        bus.i16_LpAdvAbility = 16'h0000;

        // Reset values, then the timed bring-up: lock at cycle 40, sync at 100.
        tick(3);
        checkReset("reset");
        rst = 1'b0;
        tick(2);
        check("disabled_state", bus.o3_State, 3'd0);

        bus.i_ANComplete     = 1'b1;
        bus.i16_LpAdvAbility = 16'h9800;
        p0 = pulseCnt;
        bus.i_Enable = 1'b1;
        waitState(3'd1, 100, n);
        check("pwrdn_cycles", n, PWRDN_CYCLES);
        check("rstx_pwrdn_low", bus.o_GxBPowerDown, 1'b0);
        waitState(3'd2, 100, n);
        check("rstx_cycles", n, 8);
        tick(16);
        bus.i_PllLocked = 1'b1;
        tick(1);
        check("lock_to_sync", bus.o3_State, 3'd3);
        check("sync_rst_low", bus.o_XcverDigitalRst, 1'b0);
        tick(59);
        bus.i_SyncStatus = 1'b1;
        waitState(3'd6, 20, n);
        check("bringup_state", bus.o3_State, 3'd6);
        check("bringup_link",  bus.o_LinkUp, 1'b1);
        check("bringup_speed", bus.o2_SGMIISpeed, SPD_1000);
        check("bringup_dup",   bus.o_SGMIIDuplex, 1'b1);
        check("bringup_pulse", pulseCnt - p0, 1);

        // One-cycle sync loss: immediate backoff with retry cleared, then full recovery.
        bus.i_SyncStatus = 1'b0;
        tick(1);
        bus.i_SyncStatus = 1'b1;
        check("loss_state", bus.o3_State, 3'd7);
        check("loss_link",  bus.o_LinkUp, 1'b0);
        check("loss_retry", bus.o2_RetryCnt, 2'd0);
        waitState(3'd6, 200, n);
        check("relink_state", bus.o3_State, 3'd6);
        check("relink_retry", bus.o2_RetryCnt, 2'd0);

        // Lock arriving on the last WAIT_LOCK cycle beats the timeout.
        bus.i_Enable     = 1'b0;
        bus.i_PllLocked  = 1'b0;
        bus.i_SyncStatus = 1'b0;
        bus.i_ANComplete = 1'b0;
        tick(2);
        bus.i_Enable = 1'b1;
        waitState(3'd2, 100, n);
        tick(LOCK_TIMEOUT - 1);
        check("lock_last_cycle", bus.o3_State, 3'd2);
        bus.i_PllLocked = 1'b1;
        tick(1);
        check("lock_wins_state", bus.o3_State, 3'd3);
        check("lock_wins_retry", bus.o2_RetryCnt, 2'd0);

        // Table vectors: expectation queued as stimulus is applied, popped on arrival.
        for (int i = 0; i < 8; i++) begin
            bus.i_Enable         = 1'b0;
            bus.i_ANEnable       = vecs[i].an;
            bus.i2_ForceSpeed    = vecs[i].fSpd;
            bus.i_ForceDuplex    = vecs[i].fDup;
            bus.i_PllLocked      = 1'b1;
            bus.i_SyncStatus     = 1'b1;
            bus.i_ANComplete     = 1'b1;
            bus.i16_LpAdvAbility = vecs[i].lp;
            tick(2);
            p0 = pulseCnt;
            sb.push_back(vecs[i].want);
            bus.i_Enable = 1'b1;
            n = 0;
            while (bus.o3_State !== 3'd6 && bus.o3_State !== 3'd7 && n < 200) begin
                tick(1);
                n++;
            end
            got = sb.pop_front();
            check($sformatf("v%0d_state", i),  bus.o3_State,      got.state);
            check($sformatf("v%0d_link", i),   bus.o_LinkUp,      got.linkUp);
            check($sformatf("v%0d_speed", i),  bus.o2_SGMIISpeed, got.spd);
            check($sformatf("v%0d_dup", i),    bus.o_SGMIIDuplex, got.dup);
            check($sformatf("v%0d_retry", i),  bus.o2_RetryCnt,   got.retry);
            check($sformatf("v%0d_pulses", i), pulseCnt - p0,     got.pulses);
        end

        // PLL never locks: retries run out and the fault latches.
        bus.i_Enable    = 1'b0;
        bus.i_ANEnable  = 1'b1;
        bus.i_PllLocked = 1'b0;
        tick(2);
        bus.i_Enable = 1'b1;
        n = 0;
        entries = 0;
        lockDwell = 0;
        prevSt = bus.o3_State;
        while (bus.o_Fault !== 1'b1 && n < 3000) begin
            tick(1);
            n++;
            if (entries == 0 && bus.o3_State === 3'd2) lockDwell++;
            if (bus.o3_State === 3'd7 && prevSt !== 3'd7 && bus.o_Fault === 1'b0) entries++;
            prevSt = bus.o3_State;
        end
        check("fault_set",      bus.o_Fault, 1'b1);
        check("fault_pwrdn",    bus.o_GxBPowerDown, 1'b1);
        check("fault_state",    bus.o3_State, 3'd7);
        check("fault_retry",    bus.o2_RetryCnt, 2'd3);
        check("fault_backoffs", entries, MAX_RETRY);
        check("lock_timeout",   lockDwell, LOCK_TIMEOUT);
        tick(BACKOFF_CYCLES + 20);
        check("fault_hold_state", bus.o3_State, 3'd7);
        check("fault_hold",       bus.o_Fault, 1'b1);
        bus.i_Enable = 1'b0;
        tick(1);
        bus.i_Enable = 1'b1;
        check("clear_state", bus.o3_State, 3'd0);
        check("clear_fault", bus.o_Fault, 1'b0);
        check("clear_retry", bus.o2_RetryCnt, 2'd0);
        check("clear_link",  bus.o_LinkUp, 1'b0);

        // Synchronous reset while parked in AN_WAIT.
        bus.i_Enable     = 1'b0;
        bus.i_PllLocked  = 1'b1;
        bus.i_SyncStatus = 1'b1;
        bus.i_ANComplete = 1'b0;
        tick(2);
        bus.i_Enable = 1'b1;
        waitState(3'd5, 100, n);
        check("an_wait_reached", bus.o3_State, 3'd5);
        rst = 1'b1;
        tick(1);
        checkReset("midrst");
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
